// File: rtl/svcs_hw_pkg.sv
// Shared types and constants for the SVCS hardware front end.
// Used by the transaction arbiter and its round-robin picker.
package svcs_hw_pkg;

  localparam int SVCS_MAX_SIZE  = 4096;
  localparam int SVCS_LEN_W     = 13;
  localparam int SVCS_HDR_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } svcs_arb_state_e;

  typedef struct packed {
    logic [31:0]            trnx_type;
    logic [31:0]            trnx_id;
    logic [31:0]            data_type;
    logic [SVCS_LEN_W-1:0]  n_payloads;
  } svcs_hdr_t;

endpackage

// File: rtl/svcs_trnx_arbiter_if.sv
// Requester-side and stream-side signals of the SVCS transaction arbiter.
// The master modport is the arbiter; slave is the requesters plus downstream sink.
interface svcs_trnx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0][31:0]        req_type;
  logic [N_REQ-1:0][31:0]        req_id;
  logic [N_REQ-1:0][31:0]        req_dtype;
  logic [N_REQ-1:0][LEN_W-1:0]   req_len;
  logic [N_REQ-1:0]              pay_valid;
  logic [N_REQ-1:0][DATA_W-1:0]  pay_data;
  logic [N_REQ-1:0]              pay_ready;
  logic                          out_valid;
  logic [DATA_W-1:0]             out_data;
  logic                          out_last;
  logic                          out_ready;
  logic [IDX_W-1:0]              grant_idx;
  logic                          busy;
  logic                          err_len;

  modport master (
    input  req_valid, req_type, req_id, req_dtype, req_len,
    input  pay_valid, pay_data, out_ready,
    output req_ready, pay_ready, out_valid, out_data, out_last,
    output grant_idx, busy, err_len
  );

  modport slave (
    output req_valid, req_type, req_id, req_dtype, req_len,
    output pay_valid, pay_data, out_ready,
    input  req_ready, pay_ready, out_valid, out_data, out_last,
    input  grant_idx, busy, err_len
  );

endinterface

// File: rtl/svcs_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the slot after last_idx.
// The last-grant register is owned by the parent.
module svcs_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_idx,
  output logic [N_REQ-1:0]         gnt_oh,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_valid
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan farthest-first so the nearest requester after last_idx wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last_idx) + off) % N_REQ;
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IDX_W'(idx);
        gnt_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svcs_trnx_arbiter.sv
// Shares one SVCS transaction stream among N_REQ requesters: round-robin grant,
// four registered header beats, then a combinational payload pass-through.
module svcs_trnx_arbiter
  import svcs_hw_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_PAYLOAD = SVCS_MAX_SIZE,
  parameter int LEN_W       = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  svcs_trnx_arbiter_if.master  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  svcs_arb_state_e    state_q, state_d;
  svcs_hdr_t          hdr_q, hdr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [1:0]         beat_q, beat_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               pick_bad;
  logic               hs;

  svcs_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (bus.req_valid),
    .last_idx  (last_q),
    .gnt_oh    (pick_oh),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  function automatic logic [DATA_W-1:0] hdr_word(svcs_hdr_t h, logic [1:0] beat);
    case (beat)
      2'd0:    return DATA_W'(h.trnx_type);
      2'd1:    return DATA_W'(h.trnx_id);
      2'd2:    return DATA_W'(h.data_type);
      default: return DATA_W'(h.n_payloads);
    endcase
  endfunction

  assign pick_bad = 32'(bus.req_len[pick_idx]) > 32'(MAX_PAYLOAD);
  assign hs       = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    grant_d      = grant_q;
    last_d       = last_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    bus.req_ready = '0;
    bus.err_len   = 1'b0;
    case (state_q)
      IDLE: begin
        // Acceptance pulses are combinational, so hold them off while reset is low.
        if (pick_valid && rst_n) begin
          bus.req_ready = pick_oh;
          last_d        = pick_idx;
          if (pick_bad) begin
            bus.err_len = 1'b1;
          end else begin
            hdr_d.trnx_type  = bus.req_type[pick_idx];
            hdr_d.trnx_id    = bus.req_id[pick_idx];
            hdr_d.data_type  = bus.req_dtype[pick_idx];
            hdr_d.n_payloads = SVCS_LEN_W'(bus.req_len[pick_idx]);
            grant_d          = pick_idx;
            beat_d           = 2'd0;
            out_valid_d      = 1'b1;
            out_data_d       = DATA_W'(bus.req_type[pick_idx]);
            out_last_d       = 1'b0;
            state_d          = HDR;
          end
        end
      end
      HDR: begin
        if (hs) begin
          if (beat_q == 2'(SVCS_HDR_BEATS - 1)) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            cnt_d       = LEN_W'(hdr_q.n_payloads);
            state_d     = (hdr_q.n_payloads != '0) ? PAY : IDLE;
          end else begin
            beat_d     = beat_q + 2'd1;
            out_data_d = hdr_word(hdr_q, beat_q + 2'd1);
            out_last_d = (beat_q + 2'd1 == 2'(SVCS_HDR_BEATS - 1)) &&
                         (hdr_q.n_payloads == '0);
          end
        end
      end
      PAY: begin
        if (hs) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload words bypass the header registers for zero added latency.
  assign bus.out_valid = (state_q == PAY) ? bus.pay_valid[grant_q] : out_valid_q;
  assign bus.out_data  = (state_q == PAY) ? bus.pay_data[grant_q]  : out_data_q;
  assign bus.out_last  = (state_q == PAY) ? (cnt_q == LEN_W'(1))   : out_last_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    bus.pay_ready = '0;
    if (state_q == PAY) bus.pay_ready[grant_q] = bus.out_ready;
  end

  // last_q resets to the top index so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      grant_q     <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      beat_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_svcs_trnx_arbiter.sv
// Self-checking bench for svcs_trnx_arbiter: directed vector table, hand-written
// corner sequences and randomized rounds checked against a transaction-level model.
module tb_svcs_trnx_arbiter;

  localparam int N_REQ       = 4;
  localparam int DATA_W      = 32;
  localparam int LEN_W       = 13;
  localparam int MAX_PAYLOAD = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  svcs_trnx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  svcs_trnx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_PAYLOAD(MAX_PAYLOAD), .LEN_W(LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          src;
    logic [31:0] typ;
    logic [31:0] id;
    logic [31:0] dtyp;
    int          len;
    bit          rnd;
    bit          expErr;
    int          expBusy;
  } vec_t;

  logic [31:0] hType[N_REQ], hId[N_REQ], hDtype[N_REQ], payBase[N_REQ];
  int          hLen[N_REQ], payLeft[N_REQ], payHead[N_REQ];
  bit          pend[N_REQ];
  bit          randReady;
  int          cyc, modelLast, expErrs, protoErr;
  int          acceptCyc[N_REQ], errCyc[N_REQ], payHs[N_REQ];
  bit          payRdySeen[N_REQ];
  int          firstValidCyc, busyCycles;
  bit          heldValid;
  logic [31:0] heldData;
  logic [31:0] gotData[$], expData[$];
  bit          gotLast[$], expLast[$];
  int          gotGrant[$], expGrant[$], acceptOrder[$];
  int          compared, mismatched;

  function automatic logic [31:0] payWord(int i, int k);
    return payBase[i] + 32'((k + 1) * 17);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    bus.out_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_type[i]  = hType[i];
      bus.req_id[i]    = hId[i];
      bus.req_dtype[i] = hDtype[i];
      bus.req_len[i]   = LEN_W'(hLen[i]);
      bus.pay_valid[i] = (payHead[i] < payLeft[i]);
      bus.pay_data[i]  = payWord(i, payHead[i]);
    end
  endtask

  task automatic sampleCycle();
    if ($countones(bus.req_ready) > 1 || $countones(bus.pay_ready) > 1) protoErr++;
    if (bus.err_len && bus.req_ready == '0) protoErr++;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_ready[i]) begin
        acceptCyc[i] = cyc;
        pend[i] = 1'b0;
        if (bus.err_len) errCyc[i] = cyc;
        else acceptOrder.push_back(i);
      end
      if (bus.pay_ready[i]) payRdySeen[i] = 1'b1;
      if (bus.pay_valid[i] && bus.pay_ready[i]) begin
        payHead[i]++;
        payHs[i]++;
      end
    end
    if (heldValid && !(bus.out_valid && bus.out_data == heldData)) protoErr++;
    heldValid = bus.out_valid && !bus.out_ready;
    heldData  = bus.out_data;
    if (bus.out_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      gotData.push_back(bus.out_data);
      gotLast.push_back(bus.out_last);
      gotGrant.push_back(int'(bus.grant_idx));
    end
    if (bus.busy) busyCycles++;
  endtask

  task automatic stepCycle();
    applyStimulus();
    #1;
    sampleCycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clearLog();
    for (int i = 0; i < N_REQ; i++) begin
      acceptCyc[i]  = -1;
      errCyc[i]     = -1;
      payHs[i]      = 0;
      payRdySeen[i] = 1'b0;
    end
    firstValidCyc = -1;
    busyCycles = 0;
    gotData.delete(); gotLast.delete(); gotGrant.delete();
    expData.delete(); expLast.delete(); expGrant.delete();
    acceptOrder.delete();
  endtask

  task automatic clearState();
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 1'b0; payLeft[i] = 0; payHead[i] = 0;
      hType[i] = '0; hId[i] = '0; hDtype[i] = '0; hLen[i] = 0; payBase[i] = '0;
    end
    heldValid = 1'b0;
    clearLog();
  endtask

  task automatic loadReq(input int i, input logic [31:0] t, input logic [31:0] id,
                         input logic [31:0] dt, input int len, input logic [31:0] base);
    hType[i] = t; hId[i] = id; hDtype[i] = dt; hLen[i] = len; payBase[i] = base;
    payLeft[i] = (len <= MAX_PAYLOAD) ? len : 0;
    payHead[i] = 0;
    pend[i] = 1'b1;
  endtask

  task automatic doReset(input bit checkIt);
    rst_n = 1'b0;
    clearState();
    applyStimulus();
    #1;
    if (checkIt)
      checkOutput("reset outputs",
                  64'({bus.out_valid, bus.out_data, bus.out_last, bus.req_ready,
                       bus.pay_ready, bus.grant_idx, bus.busy, bus.err_len}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelLast = N_REQ - 1;
  endtask

  // Transaction-level view: grant order follows the ring, each legal grant emits
  // its header words then its payload, illegal lengths emit nothing.
  function automatic void modelRound();
    bit p[N_REQ];
    int found, nw;
    logic [31:0] w[$];
    for (int i = 0; i < N_REQ; i++) p[i] = pend[i];
    expErrs = 0;
    for (int n = 0; n < N_REQ; n++) begin
      found = -1;
      for (int off = 1; off <= N_REQ; off++)
        if (found < 0 && p[(modelLast + off) % N_REQ]) found = (modelLast + off) % N_REQ;
      if (found < 0) break;
      p[found] = 1'b0;
      modelLast = found;
      if (hLen[found] > MAX_PAYLOAD) begin
        expErrs++;
      end else begin
        w.delete();
        w.push_back(hType[found]);
        w.push_back(hId[found]);
        w.push_back(hDtype[found]);
        w.push_back(32'(hLen[found]));
        for (int k = 0; k < hLen[found]; k++) w.push_back(payWord(found, k));
        nw = w.size();
        for (int k = 0; k < nw; k++) begin
          expData.push_back(w[k]);
          expLast.push_back(k == nw - 1);
          expGrant.push_back(found);
        end
      end
    end
  endfunction

  task automatic runRound(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      stepCycle();
      done = !bus.busy;
      for (int i = 0; i < N_REQ; i++) if (pend[i]) done = 1'b0;
    end
    checkOutput("round completes", 64'(done), 64'd1);
  endtask

  task automatic checkStream(input string tag);
    int diffs;
    diffs = 0;
    checkOutput({tag, " words"}, 64'(gotData.size()), 64'(expData.size()));
    for (int k = 0; k < gotData.size() && k < expData.size(); k++)
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotGrant[k] != expGrant[k])
        diffs++;
    checkOutput({tag, " content"}, 64'(diffs), 64'd0);
  endtask

  initial begin
    vec_t tbl[7];
    int   s, nerr, rrExpA[4], rrExpB[2];
    int   lenR;

    compared = 0; mismatched = 0; protoErr = 0; cyc = 0; randReady = 1'b0;
    tbl[0] = '{0, 32'hA5A5_0001, 32'd7,          32'd3, 2,    1'b0, 1'b0, 6};
    tbl[1] = '{1, 32'h0BAD_F00D, 32'h11,         32'd5, 0,    1'b0, 1'b0, 4};
    tbl[2] = '{2, 32'h1234_5678, 32'd9,          32'd1, 4097, 1'b0, 1'b1, 0};
    tbl[3] = '{3, 32'hCAFE_0003, 32'd3,          32'd3, 1,    1'b0, 1'b0, 5};
    tbl[4] = '{0, 32'h5EED_0016, 32'd16,         32'd2, 16,   1'b0, 1'b0, 20};
    tbl[5] = '{0, 32'h5EED_0016, 32'd16,         32'd2, 16,   1'b1, 1'b0, -1};
    tbl[6] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0, 4096, 1'b0, 1'b0, 4100};
    rrExpA = '{0, 1, 2, 3};
    rrExpB = '{0, 2};

    rst_n = 1'b1;
    clearState();
    applyStimulus();
    #2;
    doReset(1'b1);

    for (int v = 0; v < 7; v++) begin
      clearLog();
      s = tbl[v].src;
      randReady = tbl[v].rnd;
      loadReq(s, tbl[v].typ, tbl[v].id, tbl[v].dtyp, tbl[v].len, 32'h0);
      modelRound();
      runRound(tbl[v].rnd ? 4 * tbl[v].len + 100 : tbl[v].len + 40);
      checkStream("vector stream");
      checkOutput("vector req_ready", 64'(acceptCyc[s] >= 0), 64'd1);
      checkOutput("vector err_len", 64'(errCyc[s] >= 0), 64'(tbl[v].expErr));
      checkOutput("vector pay consumed", 64'(payHs[s]), 64'(tbl[v].expErr ? 0 : tbl[v].len));
      checkOutput("vector pay_ready seen", 64'(payRdySeen[s]),
                  64'(!tbl[v].expErr && tbl[v].len > 0));
      if (!tbl[v].expErr)
        checkOutput("vector hdr latency", 64'(firstValidCyc - acceptCyc[s]), 64'd1);
      if (tbl[v].expBusy >= 0)
        checkOutput("vector busy cycles", 64'(busyCycles), 64'(tbl[v].expBusy));
    end

    // Fair rotation with all four contending, then a sparse pair.
    randReady = 1'b0;
    doReset(1'b0);
    clearLog();
    for (int i = 0; i < N_REQ; i++) loadReq(i, 32'h100 + 32'(i), 32'(i), 32'd0, 1, 32'h1000 * 32'(i));
    modelRound();
    runRound(200);
    checkStream("rr4 stream");
    checkOutput("rr4 count", 64'(acceptOrder.size()), 64'd4);
    for (int k = 0; k < 4 && k < acceptOrder.size(); k++)
      checkOutput("rr4 order", 64'(acceptOrder[k]), 64'(rrExpA[k]));
    clearLog();
    loadReq(0, 32'h200, 32'd20, 32'd1, 1, 32'h5000);
    loadReq(2, 32'h202, 32'd22, 32'd1, 1, 32'h6000);
    modelRound();
    runRound(200);
    checkStream("rr02 stream");
    checkOutput("rr02 count", 64'(acceptOrder.size()), 64'd2);
    for (int k = 0; k < 2 && k < acceptOrder.size(); k++)
      checkOutput("rr02 order", 64'(acceptOrder[k]), 64'(rrExpB[k]));

    // Illegal length is dropped in one cycle and the next requester follows at once.
    doReset(1'b0);
    clearLog();
    loadReq(2, 32'hDEAD_0002, 32'd2, 32'd2, 4097, 32'h0);
    loadReq(3, 32'hBEEF_0003, 32'd3, 32'd3, 1, 32'h7000);
    modelRound();
    runRound(100);
    checkStream("err stream");
    checkOutput("err with req_ready", 64'(errCyc[2] == acceptCyc[2] && errCyc[2] >= 0), 64'd1);
    checkOutput("err next grant gap", 64'(acceptCyc[3] - errCyc[2]), 64'd1);
    checkOutput("err next hdr latency", 64'(firstValidCyc - acceptCyc[3]), 64'd1);
    checkOutput("err count", 64'(expErrs), 64'd1);

    // Reset while payload word 5 of 10 is on the bus.
    doReset(1'b0);
    clearLog();
    loadReq(0, 32'h7777_0000, 32'd1, 32'd1, 10, 32'h9000);
    for (int c = 0; c < 50 && payHead[0] < 4; c++) stepCycle();
    checkOutput("reach word 5", 64'(payHead[0]), 64'd4);
    doReset(1'b1);
    clearLog();
    loadReq(1, 32'h8888_0001, 32'd5, 32'd6, 2, 32'hA000);
    loadReq(0, 32'h8888_0000, 32'd7, 32'd8, 3, 32'hB000);
    modelRound();
    runRound(100);
    checkStream("post reset stream");
    checkOutput("post reset first grant", 64'(acceptOrder.size() > 0 ? acceptOrder[0] : -1), 64'd0);

    // Randomized rounds with back-pressure and occasional illegal lengths.
    for (int r = 0; r < 10; r++) begin
      clearLog();
      randReady = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 3) != 0 || i == r % N_REQ) begin
          lenR = ($urandom_range(0, 7) == 0) ? 4097 + int'($urandom_range(0, 50))
                                             : int'($urandom_range(0, 9));
          loadReq(i, $urandom, $urandom, $urandom, lenR, $urandom);
        end
      end
      modelRound();
      runRound(600);
      checkStream("random stream");
      nerr = 0;
      for (int i = 0; i < N_REQ; i++) if (errCyc[i] >= 0) nerr++;
      checkOutput("random err count", 64'(nerr), 64'(expErrs));
    end

    checkOutput("protocol violations", 64'(protoErr), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/svcs_trnx_arbiter.md
# svcs_trnx_arbiter

Hardware front end of the SVCS client-server handshake link. It shares one outbound SVCS transaction stream between `N_REQ` requesters. Each requester presents a transaction header and then its payload words. The block grants requesters round-robin and serializes each granted transaction as a four-word header followed by `n_payloads` data words. The output feeds the socket bridge that drives the DPI send calls.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 32, payload and header word width
- `MAX_PAYLOAD`, 4096, largest legal `n_payloads` (matches SVCS max size)
- `LEN_W`, 13, width of the length field; must hold `MAX_PAYLOAD`

Ports:
- `clk`  in  1  sole clock; all logic rising-edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `req_valid`  in  N_REQ  requester has a header pending
- `req_ready`  out  N_REQ  one-cycle pulse: header accepted
- `req_type`  in  N_REQ×32  trnx_type (32-bit hash)
- `req_id`  in  N_REQ×32  trnx_id
- `req_dtype`  in  N_REQ×32  data_type
- `req_len`  in  N_REQ×LEN_W  n_payloads
- `pay_valid`  in  N_REQ  payload word valid
- `pay_data`  in  N_REQ×DATA_W  payload word
- `pay_ready`  out  N_REQ  payload word consumed
- `out_valid`  out  1  output word valid
- `out_data`  out  DATA_W  output word
- `out_last`  out  1  last word of the transaction
- `out_ready`  in  1  downstream accepts the word
- `grant_idx`  out  $clog2(N_REQ)  current owner
- `busy`  out  1  a transaction is in flight
- `err_len`  out  1  one-cycle pulse: illegal length rejected

## Operation
- FSM states: IDLE, HDR, PAY.
- **IDLE**
  - Round-robin pick among `req_valid`, starting at the index after the last granted one. After reset, index 0 has top priority.
  - If `req_len[g] > MAX_PAYLOAD`: pulse `req_ready[g]` and `err_len`, produce no output, advance the pointer, stay in IDLE.
  - Otherwise: latch the header into a register, pulse `req_ready[g]`, set `grant_idx=g`, go to HDR with beat counter 0.
- **HDR**
  - Emits four registered beats in order: type, id, dtype, `n_payloads` (zero-extended).
  - The beat counter advances only on `out_valid && out_ready`.
  - After beat 3 is accepted: go to PAY if `n_payloads>0`, else to IDLE. With `n_payloads==0`, `out_last` is asserted on beat 3.
- **PAY**
  - Combinational pass-through from requester g: `out_valid=pay_valid[g]`, `out_data=pay_data[g]`, `pay_ready[g]=out_ready`.
  - A down-counter loads `n_payloads` and decrements on each handshake.
  - `out_last` is asserted when the counter equals 1. After the last word is accepted, advance the pointer and go to IDLE.
- Only one transaction is in flight at a time. Non-granted `pay_ready` and `req_ready` are 0. Changes on a non-granted `req_valid` are ignored until IDLE.
- Handshake rule: `out_valid` and `out_data` hold stable until `out_ready`. Requesters must hold `req_*` stable while `req_valid` is high and not yet accepted.
- `busy` = state ≠ IDLE.
- Reset mid-transaction aborts immediately with no partial completion. The round-robin pointer returns to 0.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `req_ready=0`, `pay_ready=0`, `grant_idx=0`, `busy=0`, `err_len=0`, state IDLE.
- `req_valid` high in IDLE at cycle t → `req_ready` pulse at t, header beat 0 valid at t+1.
- With `out_ready` held at 1:
  - header takes 4 cycles;
  - payload takes `n_payloads` cycles at one word per cycle, with zero added latency;
  - the next grant is evaluated in the cycle after the last handshake, so there is one IDLE bubble per transaction.
- Back-pressure: `out_ready=0` stalls the current beat indefinitely with no loss or duplication.
- An `err_len` rejection costs one cycle. The next requester can be granted in the following cycle.

## Structure
- Shared package `svcs_hw_pkg`:
  - `svcs_hdr_t` packed struct: `trnx_type`, `trnx_id`, `data_type` (32 bits each), `n_payloads`;
  - `SVCS_MAX_SIZE=4096`;
  - state enum `svcs_arb_state_e`;
  - header beat count constant `SVCS_HDR_BEATS=4`.
- Sub-module `svcs_rr_arbiter`: parameterized round-robin picker. Inputs are the request vector and the last-grant pointer; outputs are a one-hot grant, a grant index and a valid flag. It is purely combinational; the pointer register lives in the parent.

## Test plan
- Single requester 0, type=0xA5A5_0001, id=7, dtype=3, len=2, payload 0x11, 0x22, `out_ready=1` → out stream A5A50001, 7, 3, 2, 0x11, 0x22; `out_last` only on 0x22; `busy` high for 6 cycles.
- All 4 requesters valid simultaneously, each len=1 → grants in order 0,1,2,3. Then only 0 and 2 valid → grants 0 then 2.
- len=0 from requester 1 → 4 header beats, `out_last` on beat 3 (value 0), no `pay_ready[1]` asserted.
- len=4097 from requester 2 → `req_ready[2]` and `err_len` pulse in the same cycle, no `out_valid`. Requester 3 (len=1) is then granted the next cycle.
- Random `out_ready` toggling with a 16-word payload → output identical to the ready=1 run; each word is held stable while `out_ready=0`.
- `rst_n` asserted during payload word 5 of 10 → all outputs reach reset values asynchronously. After release, a fresh request from 0 starts cleanly with header beat 0.
